cylon1_decoder: RTL and testbench

Receive-side checker for the 12-LED single-eye cylon sweep. It samples the 12-bit LED word on the shared clock and decodes eye position and sweep direction. It measures dwell time per step, counts completed sweeps and flags illegal patterns or out-of-sequence steps. It sits next to the LED driver in board self-test, with outputs mapped to status registers.

---
 rtl/cylon1_decoder_pkg.sv | 21 ++
 rtl/cylon1_decoder_led_onehot_enc.sv | 38 +++
 rtl/cylon1_decoder.sv | 140 ++++++++++++++
 tb/tb_cylon1_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cylon1_decoder_pkg.sv
// Shared constants and encodings for the cylon sweep decoder.
package cylon1_decoder_pkg;

  localparam int MXLED = 12;
  localparam logic [3:0] IDX_LAST = 4'(MXLED - 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_INIT,
    ST_UP,
    ST_DOWN
  } state_t;

  typedef enum logic [1:0] {
    CL_ZERO,
    CL_ONEHOT,
    CL_ALLONES,
    CL_MULTI
  } led_class_t;

endpackage

// File: rtl/cylon1_decoder_led_onehot_enc.sv
// Classifies the registered LED word and encodes the index of a single lit LED.
module cylon1_decoder_led_onehot_enc
  import cylon1_decoder_pkg::*;
(
  input  logic [MXLED-1:0] leds_q,
  output led_class_t       led_class,
  output logic [3:0]       led_index
);

  logic [3:0] idx_terms [MXLED];

  genvar gi;
  generate
    for (gi = 0; gi < MXLED; gi++) begin : g_idx
      assign idx_terms[gi] = leds_q[gi] ? 4'(gi) : 4'd0;
    end
  endgenerate

  // The OR of per-bit indices is only meaningful when exactly one bit is set.
  always_comb begin
    led_index = 4'd0;
    for (int i = 0; i < MXLED; i++) begin
      led_index = led_index | idx_terms[i];
    end
  end

  always_comb begin
    led_class = CL_MULTI;
    if (leds_q == '0) begin
      led_class = CL_ZERO;
    end else if (&leds_q) begin
      led_class = CL_ALLONES;
    end else if ((leds_q & (leds_q - MXLED'(1))) == '0) begin
      led_class = CL_ONEHOT;
    end
  end

endmodule

// File: rtl/cylon1_decoder.sv
// Receive-side checker for a 12-LED single-eye cylon sweep: tracks eye position,
// direction, dwell per step, completed sweeps and sequence errors.
module cylon1_decoder
  import cylon1_decoder_pkg::*;
#(
  parameter int MXDWELL = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [MXLED-1:0]   leds,
  input  logic               clear_cnt,
  output logic [3:0]         position,
  output logic               valid,
  output logic               direction,
  output logic               init_seen,
  output logic               step_err,
  output logic [MXDWELL-1:0] dwell,
  output logic [7:0]         sweeps,
  output logic [7:0]         err_cnt
);

  logic [MXLED-1:0]   leds_q;
  logic [MXLED-1:0]   leds_prev;
  logic [MXDWELL-1:0] dwell_cnt;
  led_class_t         led_class;
  logic [3:0]         led_index;
  state_t             state;
  logic               change;
  logic               err_evt;
  logic               sweep_evt;
  logic               init_evt;

  cylon1_decoder_led_onehot_enc u_enc (
    .leds_q    (leds_q),
    .led_class (led_class),
    .led_index (led_index)
  );

  assign change = (leds_q != leds_prev);

  // Event decode: everything here only matters on a pattern change.
  always_comb begin
    err_evt   = 1'b0;
    sweep_evt = 1'b0;
    init_evt  = 1'b0;
    if (change) begin
      case (led_class)
        CL_ALLONES: init_evt = 1'b1;
        CL_ONEHOT: begin
          if (state == ST_UP) begin
            err_evt = (led_index != 4'(position + 4'd1));
          end else if (state == ST_DOWN) begin
            err_evt   = (led_index != 4'(position - 4'd1));
            sweep_evt = !err_evt && (led_index == 4'd0);
          end
        end
        default: err_evt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      leds_q    <= '0;
      leds_prev <= '0;
      dwell_cnt <= '0;
      dwell     <= '0;
      state     <= ST_WAIT;
      position  <= 4'd0;
      valid     <= 1'b0;
      direction <= 1'b0;
      init_seen <= 1'b0;
      step_err  <= 1'b0;
      sweeps    <= 8'd0;
      err_cnt   <= 8'd0;
    end else begin
      leds_q    <= leds;
      leds_prev <= leds_q;
      step_err  <= err_evt;

      if (change) begin
        dwell_cnt <= MXDWELL'(1);
        dwell     <= dwell_cnt;
      end else if (dwell_cnt != '1) begin
        dwell_cnt <= dwell_cnt + MXDWELL'(1);
      end

      if (change) begin
        case (led_class)
          CL_ALLONES: begin
            state <= ST_INIT;
            valid <= 1'b0;
          end
          CL_ONEHOT: begin
            if (state == ST_WAIT || state == ST_INIT || !err_evt) begin
              position <= led_index;
              valid    <= 1'b1;
              if (led_index == IDX_LAST) begin
                state     <= ST_DOWN;
                direction <= 1'b0;
              end else if (state != ST_DOWN || led_index == 4'd0) begin
                state     <= ST_UP;
                direction <= 1'b1;
              end
            end else begin
              state <= ST_WAIT;
              valid <= 1'b0;
            end
          end
          default: begin
            // Errors while unlocked leave the state where it was.
            if (state == ST_UP || state == ST_DOWN) begin
              state <= ST_WAIT;
              valid <= 1'b0;
            end
          end
        endcase
      end

      if (clear_cnt) begin
        err_cnt <= 8'd0;
      end else if (err_evt && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end

      if (clear_cnt) begin
        sweeps <= 8'd0;
      end else if (sweep_evt && sweeps != 8'hFF) begin
        sweeps <= sweeps + 8'd1;
      end

      if (clear_cnt) begin
        init_seen <= 1'b0;
      end else if (init_evt) begin
        init_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cylon1_decoder.sv
// Scoreboard bench for cylon1_decoder: stimulus queues expected results per
// pattern change, a monitor pops and compares when the decoded result appears.
module tb_cylon1_decoder;

  localparam int DW = 8;

  logic          clock;
  logic          reset;
  logic [11:0]   leds;
  logic          clear_cnt;
  logic [3:0]    position;
  logic          valid;
  logic          direction;
  logic          init_seen;
  logic          step_err;
  logic [DW-1:0] dwell;
  logic [7:0]    sweeps;
  logic [7:0]    err_cnt;

  cylon1_decoder #(.MXDWELL(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .leds      (leds),
    .clear_cnt (clear_cnt),
    .position  (position),
    .valid     (valid),
    .direction (direction),
    .init_seen (init_seen),
    .step_err  (step_err),
    .dwell     (dwell),
    .sweeps    (sweeps),
    .err_cnt   (err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] pat;
    logic [3:0]  pos;
    logic        valid;
    logic        dir;
    logic        serr;
    int          dwell;
    logic        dwchk;
    int          sweeps;
    int          err;
    logic        init;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   txn = 0;
  int   e_sw = 0;
  int   e_err = 0;
  logic e_init = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drv(input logic [11:0] pat, input int hold, input logic [3:0] p,
                     input logic v, input logic d, input logic se, input int dw,
                     input logic dwc);
    exp_t e;
    e.pat = pat; e.pos = p; e.valid = v; e.dir = d; e.serr = se;
    e.dwell = dw; e.dwchk = dwc; e.sweeps = e_sw; e.err = e_err; e.init = e_init;
    q.push_back(e);
    leds = pat;
    repeat (hold) @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_position"}, position, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_direction"}, direction, 0);
    chk({tag, "_init_seen"}, init_seen, 0);
    chk({tag, "_step_err"}, step_err, 0);
    chk({tag, "_dwell"}, dwell, 0);
    chk({tag, "_sweeps"}, sweeps, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  // Monitor: mirrors the two-stage input pipeline to know when a result is due.
  initial begin
    logic [11:0] tb_q;
    logic [11:0] tb_prev;
    logic        ev;
    exp_t        e;
    tb_q = '0;
    tb_prev = '0;
    forever begin
      @(posedge clock);
      if (reset) begin
        tb_q = '0;
        tb_prev = '0;
        ev = 1'b0;
      end else begin
        ev = (tb_q != tb_prev);
        tb_prev = tb_q;
        tb_q = leds;
      end
      #1;
      if (ev) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event actual=1 required=0");
        end else begin
          e = q.pop_front();
          txn++;
          $display("txn %0d leds=%03h pos=%0d valid=%0b dir=%0b init=%0b serr=%0b dwell=%0d sweeps=%0d err=%0d",
                   txn, e.pat, position, valid, direction, init_seen, step_err, dwell, sweeps, err_cnt);
          chk("valid", valid, e.valid);
          if (e.valid) chk("position", position, e.pos);
          chk("direction", direction, e.dir);
          chk("step_err", step_err, e.serr);
          if (e.dwchk) chk("dwell", dwell, e.dwell);
          chk("sweeps", sweeps, e.sweeps);
          chk("err_cnt", err_cnt, e.err);
          chk("init_seen", init_seen, e.init);
        end
      end else if (!reset) begin
        chk("step_err_idle", step_err, 0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    leds = 12'h000;
    clear_cnt = 1'b0;
    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Init pattern, then a full legal sweep 0..11..0 with the final 0 held twice as long.
    e_init = 1'b1;
    drv(12'hFFF, 5, 4'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    drv(12'h001, 10, 4'd0, 1'b1, 1'b1, 1'b0, 5, 1'b1);
    for (int i = 1; i <= 10; i++) drv(12'(1 << i), 10, 4'(i), 1'b1, 1'b1, 1'b0, 10, 1'b1);
    drv(12'h800, 10, 4'd11, 1'b1, 1'b0, 1'b0, 10, 1'b1);
    for (int i = 10; i >= 1; i--) drv(12'(1 << i), 10, 4'(i), 1'b1, 1'b0, 1'b0, 10, 1'b1);
    e_sw = 1;
    drv(12'h001, 20, 4'd0, 1'b1, 1'b1, 1'b0, 10, 1'b1);
    drv(12'h002, 10, 4'd1, 1'b1, 1'b1, 1'b0, 20, 1'b1);
    drv(12'h004, 10, 4'd2, 1'b1, 1'b1, 1'b0, 10, 1'b1);
    drv(12'h008, 10, 4'd3, 1'b1, 1'b1, 1'b0, 10, 1'b1);
    drv(12'h010, 10, 4'd4, 1'b1, 1'b1, 1'b0, 10, 1'b1);

    // Illegal jump 4 -> 7, then relock on bit 0.
    e_err = 1;
    drv(12'h080, 10, 4'd4, 1'b0, 1'b1, 1'b1, 10, 1'b1);
    drv(12'h001, 10, 4'd0, 1'b1, 1'b1, 1'b0, 10, 1'b1);
    drv(12'h002, 10, 4'd1, 1'b1, 1'b1, 1'b0, 10, 1'b1);

    // ZERO from UP, then MULTI while waiting.
    e_err = 2;
    drv(12'h000, 10, 4'd1, 1'b0, 1'b1, 1'b1, 10, 1'b1);
    e_err = 3;
    drv(12'h003, 10, 4'd1, 1'b0, 1'b1, 1'b1, 10, 1'b1);

    // Long hold saturates dwell.
    drv(12'h020, (1 << DW) + 5, 4'd5, 1'b1, 1'b1, 1'b0, 10, 1'b1);
    drv(12'h040, 10, 4'd6, 1'b1, 1'b1, 1'b0, (1 << DW) - 1, 1'b1);

    // Asynchronous reset mid-sweep at position 6.
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    e_sw = 0;
    e_err = 0;
    e_init = 1'b0;
    drv(12'h040, 10, 4'd6, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    drv(12'h080, 10, 4'd7, 1'b1, 1'b1, 1'b0, 10, 1'b1);

    // Error saturation, then clear on the same cycle as an error.
    e_init = 1'b1;
    drv(12'hFFF, 3, 4'd7, 1'b0, 1'b1, 1'b0, 10, 1'b1);
    e_err = 1;
    drv(12'h000, 1, 4'd7, 1'b0, 1'b1, 1'b1, 3, 1'b1);
    for (int i = 0; i < 300; i++) begin
      e_err = (e_err < 255) ? e_err + 1 : 255;
      drv((i % 2 == 0) ? 12'h003 : 12'h000, 1, 4'd7, 1'b0, 1'b1, 1'b1, 1, 1'b1);
    end
    e_err = 0;
    e_init = 1'b0;
    drv(12'h003, 1, 4'd7, 1'b0, 1'b1, 1'b1, 1, 1'b1);
    clear_cnt = 1'b1;
    @(negedge clock);
    clear_cnt = 1'b0;
    e_err = 1;
    drv(12'h000, 10, 4'd7, 1'b0, 1'b1, 1'b1, 2, 1'b1);

    repeat (5) @(negedge clock);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
